// File: rtl/drca_pkg.sv
// Shared definitions for the digit-serial ripple add/subtract blocks:
// controller states, default widths and a width helper.
package drca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DRCA_N = 8;
    localparam int DRCA_W = 2;

    // ceil(log2(value)), but never less than 1 so single-chunk configs still get a counter bit
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rbs_chunk.sv
// Combinational W-bit ripple-borrow subtractor: {bout, d} = a - b - bin,
// built from one full-subtractor slice per bit.
module rbs_chunk #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] brw;

    assign brw[0] = bin;

    for (genvar gi = 0; gi < W; gi++) begin : g_slice
        assign d[gi]       = a[gi] ^ b[gi] ^ brw[gi];
        // Borrow out when a=0,b=1, or when a==b and a borrow is already pending
        assign brw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & brw[gi]);
    end

    assign bout = brw[W];

endmodule

// File: rtl/rbs_serial.sv
// Digit-serial subtractor: D = A - B - Bin, W bits per clock, borrow kept in a
// register between chunks; valid/ready handshakes on both operand and result sides.
module rbs_serial
    import drca_pkg::*;
#(
    parameter int N = DRCA_N,
    parameter int W = DRCA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         v,
    output logic         z
);

    if ((W < 1) || (N % W != 0)) begin : g_bad_width
        $error("rbs_serial: N must be a non-zero multiple of W");
    end

    localparam int            NCH  = N / W;
    localparam int            IW   = clog2_min1(NCH);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic          borrow_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  diff_q;
    logic          bout_q;
    logic          v_q;
    logic          z_q;

    logic [W-1:0]  chunk_a;
    logic [W-1:0]  chunk_b;
    logic [W-1:0]  chunk_d;
    logic          chunk_bout;
    logic [N-1:0]  diff_d;

    always_comb begin
        chunk_a = a_q[idx_q * W +: W];
        chunk_b = b_q[idx_q * W +: W];
    end

    rbs_chunk #(.W(W)) u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .bin  (borrow_q),
        .d    (chunk_d),
        .bout (chunk_bout)
    );

    // Full difference as it will look after this chunk is written; the flags need it on the last chunk
    always_comb begin
        diff_d = diff_q;
        diff_d[idx_q * W +: W] = chunk_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= '0;
                        diff_q   <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    diff_q   <= diff_d;
                    borrow_q <= chunk_bout;
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        bout_q  <= chunk_bout;
                        z_q     <= (diff_d == '0);
                        v_q     <= (a_q[N-1] != b_q[N-1]) && (diff_d[N-1] != a_q[N-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = diff_q;
    assign bout      = bout_q;
    assign v         = v_q;
    assign z         = z_q;

endmodule

// File: tb/tb_rbs_serial.sv
// Bench for rbs_serial: three instances (W=2, W=8, W=1) share stimulus; a
// cycle-level model derived from the arithmetic rules is compared every cycle.
module tb_rbs_serial;

    localparam int N = 8;
    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{4, 1, 8};

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [N-1:0]    a_i;
    logic [N-1:0]    b_i;
    logic            bin_i;

    logic [NDUT-1:0] in_ready_w;
    logic [NDUT-1:0] out_valid_w;
    logic [NDUT-1:0] bout_w;
    logic [NDUT-1:0] v_w;
    logic [NDUT-1:0] z_w;
    logic [N-1:0]    d_w [NDUT];

    int checks = 0;
    int errors = 0;

    rbs_serial #(.N(N), .W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a_i), .b(b_i), .bin(bin_i), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .d(d_w[0]), .bout(bout_w[0]), .v(v_w[0]), .z(z_w[0])
    );
    rbs_serial #(.N(N), .W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a_i), .b(b_i), .bin(bin_i), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .d(d_w[1]), .bout(bout_w[1]), .v(v_w[1]), .z(z_w[1])
    );
    rbs_serial #(.N(N), .W(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a_i), .b(b_i), .bin(bin_i), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .d(d_w[2]), .bout(bout_w[2]), .v(v_w[2]), .z(z_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           cyc;
    bit           busy   [NDUT];
    int           acc    [NDUT];
    logic [N-1:0] exp_d  [NDUT];
    logic         exp_bo [NDUT];
    logic         exp_v  [NDUT];
    logic         exp_z  [NDUT];

    function automatic logic [N-1:0] m_diff(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return N'(r + 256);
    endfunction

    function automatic logic m_borrow(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        return int'(x) < int'(y) + int'(c);
    endfunction

    function automatic logic m_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        return (s > 127) || (s < -128);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int k = 0; k < NDUT; k++) busy[k] <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < NDUT; k++) begin
                if (busy[k]) begin
                    if ((cyc - acc[k] >= LAT[k]) && out_ready) busy[k] <= 1'b0;
                end else if (in_valid) begin
                    busy[k]   <= 1'b1;
                    acc[k]    <= cyc + 1;
                    exp_d[k]  <= m_diff(a_i, b_i, bin_i);
                    exp_bo[k] <= m_borrow(a_i, b_i, bin_i);
                    exp_v[k]  <= m_ovf(a_i, b_i, bin_i);
                    exp_z[k]  <= (m_diff(a_i, b_i, bin_i) == '0);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    bit           capt   [NDUT];
    logic [N-1:0] cap_d  [NDUT];
    logic [3:0]   cap_f  [NDUT];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                logic ev;
                ev = busy[k] && (cyc - acc[k] >= LAT[k]);
                chk("in_ready", k, 32'(in_ready_w[k]), 32'(!busy[k]));
                chk("out_valid", k, 32'(out_valid_w[k]), 32'(ev));
                if (ev) begin
                    chk("d", k, 32'(d_w[k]), 32'(exp_d[k]));
                    chk("bout", k, 32'(bout_w[k]), 32'(exp_bo[k]));
                    chk("v", k, 32'(v_w[k]), 32'(exp_v[k]));
                    chk("z", k, 32'(z_w[k]), 32'(exp_z[k]));
                    if (out_ready) begin
                        capt[k]  = 1'b1;
                        cap_d[k] = d_w[k];
                        cap_f[k] = {1'b0, bout_w[k], v_w[k], z_w[k]};
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       v;
        logic       z;
        bit         hold;
    } vec_t;

    vec_t vecs [8] = '{
        '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0},
        '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0},
        '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0},
        '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0},
        '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0},
        '{8'h3C, 8'h1E, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1},
        '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_busy();
        bit r;
        r = 1'b0;
        for (int k = 0; k < NDUT; k++) r |= busy[k];
        return r;
    endfunction

    task automatic wait_idle(input string name);
        for (int t = 0; t < 60 && any_busy(); t++) tick();
        checks++;
        if (any_busy()) begin
            errors++;
            $display("FAIL %s: timeout waiting for result handshake", name);
        end
    endtask

    task automatic check_reset_values(input string name);
        for (int k = 0; k < NDUT; k++) begin
            chk({name, "_in_ready"}, k, 32'(in_ready_w[k]), 32'd1);
            chk({name, "_out_valid"}, k, 32'(out_valid_w[k]), 32'd0);
            chk({name, "_d"}, k, 32'(d_w[k]), 32'd0);
            chk({name, "_flags"}, k, {29'd0, bout_w[k], v_w[k], z_w[k]}, 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t t);
        for (int k = 0; k < NDUT; k++) capt[k] = 1'b0;
        a_i = t.a; b_i = t.b; bin_i = t.bin;
        in_valid  = 1'b1;
        out_ready = !t.hold;
        tick();
        in_valid = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom); bin_i = 1'($urandom);
        if (t.hold) begin
            repeat (9) tick();
            in_valid = 1'b1;
            a_i = 8'h11; b_i = 8'h22;
            repeat (5) tick();
            in_valid = 1'b0;
            repeat (4) tick();
            out_ready = 1'b1;
        end
        wait_idle("op_done");
        for (int k = 0; k < NDUT; k++) begin
            chk("captured", k, 32'(capt[k]), 32'd1);
            chk("lit_d", k, 32'(cap_d[k]), 32'(t.d));
            chk("lit_flags", k, 32'(cap_f[k]), {29'd0, t.bo, t.v, t.z});
        end
        $display("op a=%02h b=%02h bin=%0d hold=%0d -> d=%02h/%02h/%02h expect %02h",
                 t.a, t.b, t.bin, t.hold, cap_d[0], cap_d[1], cap_d[2], t.d);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_i = '0; b_i = '0; bin_i = 1'b0;
        #3;
        check_reset_values("por");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during the second RUN cycle of the W=2 instance
        a_i = 8'hA5; b_i = 8'h5A; bin_i = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        $display("reset asserted mid-operation at %0t", $time);
        tick(); tick();
        rst_n = 1'b1;
        repeat (12) tick();

        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rbs_serial.md
Name: rbs_serial

Overview:
- Digit-serial ripple-borrow subtractor: computes D = A - B - Bin over N bits, W bits per clock, with the borrow held in a register between chunks.
- It is the subtracting counterpart of the team's combinational ripple-carry adder and sits beside it in the adder simulation suite.
- Operands enter through a valid/ready handshake; the result and status flags leave through a separate valid/ready handshake.
- It is used to compare area and latency against the single-cycle adder path.

Parameters:
- N, 8, operand/result bit width.
- W, 2, bits processed per RUN cycle (chunk width). N % W == 0 is required; any other value must cause an elaboration error. W = N is legal and gives a single RUN cycle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  N  minuend (unsigned / two's complement)
- b  input  N  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- d  output  N  difference
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned)
- v  output  1  signed overflow
- z  output  1  d == 0

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = IDLE, chunk index = 0, borrow register = 0.
  - in_ready = 1, out_valid = 0, d = 0, bout = 0, v = 0, z = 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state, with no combinational path from any input.
- IDLE:
  - On in_valid at a clock edge: capture a, b, borrow <= bin, idx <= 0, clear the d register, go to RUN.
  - Otherwise stay in IDLE.
- RUN: each cycle processes one chunk.
  - Compute {borrow', d[idx*W +: W]} = a[idx*W +: W] - b[idx*W +: W] - borrow.
  - Register both results, then idx <= idx + 1.
  - After the chunk with idx == N/W - 1, go to DONE and register the flags:
    - bout = final borrow.
    - z = (full d == 0).
    - v = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]).
- Latency: out_valid rises exactly N/W clock edges after the accepting edge (8/2 = 4 cycles by default).
- DONE:
  - Hold d, bout, v and z stable while out_ready = 0, for any number of cycles.
  - On out_ready = 1 at an edge, go to IDLE. out_valid drops and in_ready rises on the same edge.
- Throughput: one operation per N/W + 2 cycles. No overlap of input acceptance with DONE.
- Handshake rules:
  - Operands are sampled only on the accepting edge. Later changes to a, b, bin or in_valid are ignored until the block is back in IDLE.
  - out_ready is ignored outside DONE.
- Outputs outside DONE: d and the flags keep their last registered values. Consumers use them only when out_valid = 1.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The in-flight result is discarded and no out_valid pulse occurs.
- Arithmetic:
  - Borrow is the inverted carry of a + ~b + ~bin, restricted to the current chunk.
  - Results wrap modulo 2^N.
  - idx is sized clog2(N/W) with a minimum width of 1, and never exceeds N/W - 1.

Decomposition:
- drca_pkg holds the shared definitions:
  - State enum (IDLE, RUN, DONE).
  - Default width constants DRCA_N = 8 and DRCA_W = 2.
  - Function clog2_min1.
- Sub-module rbs_chunk (parameter W): combinational W-bit ripple-borrow subtractor with inputs a, b, bin and outputs d, bout, built from full-subtractor bit slices.
- rbs_serial instantiates one rbs_chunk and holds the FSM, operand registers, index counter and borrow register.

Test Plan:
- Basic subtract: a=0x05, b=0x03, bin=0, N=8, W=2 -> out_valid exactly 4 cycles after accept; d=0x02, bout=0, v=0, z=0.
- Unsigned underflow: a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1, v=0, z=0.
- Signed overflow: a=0x80, b=0x01 -> d=0x7F, bout=0, v=1. Separately, a=0x7F, b=0xFF -> d=0x80, bout=1, v=1.
- Borrow-in with zero result: a=0x10, b=0x0F, bin=1 -> d=0x00, z=1, bout=0. A borrow must ripple across chunk boundaries.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> d and flags stable, in_ready=0, and a new in_valid is ignored.
  - Assert out_ready -> in_ready=1 on the next cycle, and a second op (0xFF - 0x01 = 0xFE) completes correctly.
- Reset and configs:
  - Drop rst_n during the 2nd RUN cycle -> all outputs at reset values immediately, with no out_valid afterwards.
  - Rerun the first four scenarios with W=8 (1-cycle latency) and W=1 (8-cycle latency) and check identical results.
